sm3_msg_expand: RTL and testbench
=================================

// Module: sm3_msg_expand
// PURPOSE
//  SM3 message-expansion stage. Accepts one padded 512-bit block and streams W_j and W'_j
//  for j = 0..63, one round per handshake, to the compression round (A..H update, FF/GG).
//  Uses a 16-word sliding window, so W_0..W_67 are never stored at once.
// PARAMETERS
//  NUM_ROUNDS  64  rounds emitted per block; fixed by SM3, do not override
// PORTS
//  input_clk      in   1      clock; all state changes on rising edge
//  input_rst_n    in   1      synchronous, active-low reset
//  input_start    in   1      load request; accepted only when output_busy == 0
//  input_block    in   [0:511] padded block; word W_i = input_block[32*i +: 32], i.e. W_0 = bits 0:31
//  input_ready    in   1      downstream (compression round) can take the current W/W'
//  output_busy    out  1      high from the start acceptance until the j=63 handshake
//  output_valid   out  1      output_j / output_W / output_Wp are valid
//  output_j       out  [0:5]  round index of the presented words
//  output_W       out  [0:31] W_j
//  output_Wp      out  [0:31] W'_j = W_j ^ W_{j+4}
//  output_done    out  1      one-cycle pulse after the j=63 handshake
// BEHAVIOUR
//  - Reset (input_rst_n == 0 at an edge): state goes to IDLE; window, j, busy, valid and done
//    are all cleared to 0. Reset takes priority over every other input.
//    A reset mid-block aborts the block with no done pulse.
//  - FSM has two states, IDLE and RUN.
//    IDLE -> RUN: on input_start at an edge. The window R[0..15] is loaded with W_0..W_15 and j is set to 0.
//    RUN -> IDLE: on the handshake (valid & ready) with j == NUM_ROUNDS-1.
//  - Latency: start sampled at edge k gives output_valid = 1 and output_j = 0 in cycle k+1.
//  - Outputs are combinational from the registers:
//    output_W = R[0]; output_Wp = R[0] ^ R[4]; output_valid = (state == RUN).
//  - On a handshake in RUN:
//    - R[i] <= R[i+1] for i = 0..14.
//    - R[15] <= P1(R[0] ^ R[7] ^ ROTL(R[13],15)) ^ ROTL(R[3],7) ^ R[10].
//    - j <= j + 1.
//    - P1(x) = x ^ ROTL(x,15) ^ ROTL(x,23). All arithmetic is 32-bit XOR/rotate; no carries.
//  - Stall: valid with !ready holds the window, j and all outputs bit-stable. No output may change
//    while valid is high and unacknowledged.
//  - output_busy = (state == RUN).
//  - input_start while busy is ignored. input_block is sampled only on the accepting edge.
//  - output_done: a registered pulse in the cycle after the final handshake (state already IDLE).
//    An input_start in that same cycle is accepted (back-to-back blocks, 1-cycle bubble).
//  - j never wraps inside a block. After the final handshake it returns to 0.
//    The window values computed past W_67 are don't-care.
// STRUCTURE
//  - sm3_pkg (shared): word_t = logic [0:31]; SM3_ROUNDS = 64;
//    function rotl32(word_t x, int n); function p1(word_t x).
//    FF/GG/P0 belong there too for the compression round.
//  - Sub-module sm3_w_next (combinational): inputs R[0], R[3], R[7], R[10], R[13]; output W_{j+16}.
//  - Top level holds the FSM, the 16x32 window, the j counter and the done register.
// TESTING
//  Stimulus block = "abc" padded: 61626380, then 14 words of 00000000, then 00000018.
//  1. Reset, start with the abc block, ready held at 1:
//     - j=0 gives W=61626380, W'=61626380.
//     - j=16 gives W=9092e200; j=18 gives W=000c0606; j=19 gives W=719c70ed.
//     - j=12 gives W'=9092e200.
//     - 64 consecutive valid cycles, then a done pulse one cycle after j=63.
//  2. Random ready-low stalls: W/W'/j stay stable while stalled. The full 64-word sequence is
//     identical to scenario 1, and the done count is 1.
//  3. Start pulsed at j=5 with a different block: ignored; the sequence continues with the original block.
//  4. input_rst_n=0 for one edge at j=30: next cycle valid=0, busy=0, j=0, no done pulse.
//     A following start gives j=0, W=61626380 again.
//  5. Start asserted in the done cycle with the same block: accepted. The second block's j=0 appears
//     on the next cycle and its outputs match scenario 1.
//  6. Start held high continuously across 3 blocks: exactly 3 done pulses, each block 64 handshakes.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared SM3 types and word-level primitives used by message expansion and compression.
package sm3_pkg;

  typedef logic [0:31] word_t;

  localparam int SM3_ROUNDS = 64;

  // Rotation amount is taken modulo 32; a zero amount returns x unchanged.
  function automatic word_t rotl32(word_t x, int n);
    int unsigned s;
    s = n & 31;
    if (s == 0) return x;
    return word_t'((x << s) | (x >> (32 - s)));
  endfunction

  function automatic word_t p0(word_t x);
    return x ^ rotl32(x, 9) ^ rotl32(x, 17);
  endfunction

  function automatic word_t p1(word_t x);
    return x ^ rotl32(x, 15) ^ rotl32(x, 23);
  endfunction

  function automatic word_t ff_j(word_t x, word_t y, word_t z, int j);
    if (j < 16) return x ^ y ^ z;
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic word_t gg_j(word_t x, word_t y, word_t z, int j);
    if (j < 16) return x ^ y ^ z;
    return (x & y) | (~x & z);
  endfunction

endpackage

// File: rtl/sm3_w_next.sv
// Combinational next-word generator: W_{j+16} from the current 16-word window taps.
module sm3_w_next
  import sm3_pkg::*;
(
  input  word_t r0_i,
  input  word_t r3_i,
  input  word_t r7_i,
  input  word_t r10_i,
  input  word_t r13_i,
  output word_t w16_o
);

  assign w16_o = p1(r0_i ^ r7_i ^ rotl32(r13_i, 15)) ^ rotl32(r3_i, 7) ^ r10_i;

endmodule

// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: streams W_j / W'_j for j = 0..63 from a 16-word sliding window.
module sm3_msg_expand
  import sm3_pkg::*;
#(
  parameter int NUM_ROUNDS = SM3_ROUNDS
) (
  input  logic         input_clk,
  input  logic         input_rst_n,
  input  logic         input_start,
  input  logic [0:511] input_block,
  input  logic         input_ready,
  output logic         output_busy,
  output logic         output_valid,
  output logic [0:5]   output_j,
  output logic [0:31]  output_W,
  output logic [0:31]  output_Wp,
  output logic         output_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:5] J_LAST  = 6'(NUM_ROUNDS - 1);

  logic [0:0] state_q, state_d;
  word_t      win_q [16];
  word_t      win_d [16];
  logic [0:5] j_q, j_d;
  logic       done_q, done_d;
  word_t      w_next;
  logic       hs;

  assign hs = (state_q == ST_RUN) && input_ready;

  sm3_w_next u_w_next (
    .r0_i  (win_q[0]),
    .r3_i  (win_q[3]),
    .r7_i  (win_q[7]),
    .r10_i (win_q[10]),
    .r13_i (win_q[13]),
    .w16_o (w_next)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    done_d  = 1'b0;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

    case (state_q)
      ST_IDLE: begin
        if (input_start) begin
          state_d = ST_RUN;
          j_d     = '0;
          for (int i = 0; i < 16; i++) win_d[i] = input_block[32*i +: 32];
        end
      end
      default: begin
        // Without a handshake everything holds, keeping outputs bit-stable during a stall.
        if (hs) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = w_next;
          if (j_q == J_LAST) begin
            state_d = ST_IDLE;
            j_d     = '0;
            done_d  = 1'b1;
          end else begin
            j_d = j_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (!input_rst_n) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign output_busy  = (state_q == ST_RUN);
  assign output_valid = (state_q == ST_RUN);
  assign output_j     = j_q;
  assign output_W     = win_q[0];
  assign output_Wp    = win_q[0] ^ win_q[4];
  assign output_done  = done_q;

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Bench for sm3_msg_expand: known-answer table on the "abc" block plus a recurrence model for random blocks.
module tb_sm3_msg_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:511] blk;
  logic         ready;
  logic         busy, valid, done;
  logic [0:5]   j;
  logic [0:31]  w, wp;

  always #5 clk = ~clk;

  sm3_msg_expand dut (
    .input_clk    (clk),
    .input_rst_n  (rst_n),
    .input_start  (start),
    .input_block  (blk),
    .input_ready  (ready),
    .output_busy  (busy),
    .output_valid (valid),
    .output_j     (j),
    .output_W     (w),
    .output_Wp    (wp),
    .output_done  (done)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mw [0:67];
  logic [31:0] cap_w  [0:63];
  logic [31:0] cap_wp [0:63];
  logic [31:0] ref_w  [0:63];
  logic [31:0] ref_wp [0:63];

  typedef struct {
    int          jj;
    logic [31:0] ew;
    logic [31:0] ewp;
    bit          do_w;
    bit          do_wp;
  } kat_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1m(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  // Full W_0..W_67 expansion straight from the SM3 recurrence.
  task automatic build_model(input logic [0:511] b);
    for (int i = 0; i < 16; i++) mw[i] = b[32*i +: 32];
    for (int i = 16; i < 68; i++)
      mw[i] = p1m(mw[i-16] ^ mw[i-9] ^ rl(mw[i-3], 15)) ^ rl(mw[i-13], 7) ^ mw[i-6];
  endtask

  function automatic logic [0:511] abc_block();
    logic [0:511] b;
    b = '0;
    b[0 +: 32]      = 32'h61626380;
    b[32*15 +: 32]  = 32'h00000018;
    return b;
  endfunction

  function automatic logic [0:511] rand_block();
    logic [0:511] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic start_block(input logic [0:511] b);
    build_model(b);
    blk   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_valid", valid, 1);
    chk("start_j", j, 0);
  endtask

  // Consumes one block from the current cycle (valid expected) to the done cycle.
  task automatic run_stream(input int stall_pct, input int inject_j,
                            input logic [0:511] other, output int dones);
    int hs, cyc;
    bit prev_stall;
    logic [31:0] pw, pwp;
    logic [5:0]  pj;
    hs = 0; cyc = 0; prev_stall = 0; dones = 0;
    pw = '0; pwp = '0; pj = '0;
    while (hs < 64 && cyc < 3000) begin
      if (done) dones++;
      chk("run_valid", valid, 1);
      chk("run_busy", busy, 1);
      chk("run_j", j, hs);
      chk("run_W", w, mw[hs]);
      chk("run_Wp", wp, mw[hs] ^ mw[hs+4]);
      if (prev_stall) begin
        chk("stall_W", w, pw);
        chk("stall_Wp", wp, pwp);
        chk("stall_j", j, pj);
      end
      cap_w[hs]  = w;
      cap_wp[hs] = wp;
      pw = w; pwp = wp; pj = j;
      ready = ($urandom_range(99) >= stall_pct);
      if (hs == inject_j) begin
        start = 1'b1;
        blk   = other;
      end
      prev_stall = !ready;
      if (ready) hs++;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 3000) chk("stream_timeout", 1, 0);
    chk("end_done", done, 1);
    chk("end_valid", valid, 0);
    chk("end_busy", busy, 0);
    chk("end_j", j, 0);
    if (done) dones++;
  endtask

  task automatic seq_compare(input string name);
    int diff;
    diff = 0;
    for (int i = 0; i < 64; i++)
      if (cap_w[i] !== ref_w[i] || cap_wp[i] !== ref_wp[i]) diff++;
    chk(name, diff, 0);
  endtask

  initial begin
    kat_t kat [6];
    int d, k, hs6, dn6;
    logic [0:511] abc;

    abc = abc_block();
    kat[0] = '{0,  32'h61626380, 32'h61626380, 1, 1};
    kat[1] = '{16, 32'h9092e200, 32'h0,        1, 0};
    kat[2] = '{18, 32'h000c0606, 32'h0,        1, 0};
    kat[3] = '{19, 32'h719c70ed, 32'h0,        1, 0};
    kat[4] = '{12, 32'h0,        32'h9092e200, 0, 1};
    kat[5] = '{15, 32'h00000018, 32'h0,        1, 0};

    rst_n = 1'b0; start = 1'b0; ready = 1'b0; blk = rand_block();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_j", j, 0);
    chk("rst_W", w, 0);
    chk("rst_Wp", wp, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", valid, 0);

    // Scenario 1: abc block, ready always high
    start_block(abc);
    run_stream(0, -1, '0, d);
    chk("s1_dones", d, 1);
    for (int i = 0; i < 6; i++) begin
      if (kat[i].do_w)  chk($sformatf("kat_W_j%0d", kat[i].jj),  cap_w[kat[i].jj],  kat[i].ew);
      if (kat[i].do_wp) chk($sformatf("kat_Wp_j%0d", kat[i].jj), cap_wp[kat[i].jj], kat[i].ewp);
    end
    for (int i = 0; i < 64; i++) begin
      ref_w[i] = cap_w[i];
      ref_wp[i] = cap_wp[i];
    end
    @(posedge clk); #1;
    chk("s1_done_pulse_width", done, 0);

    // Scenario 2: random stalls
    start_block(abc);
    run_stream(40, -1, '0, d);
    chk("s2_dones", d, 1);
    seq_compare("s2_seq_same");

    // Scenario 3: start while busy is ignored
    @(posedge clk); #1;
    start_block(abc);
    run_stream(20, 5, rand_block(), d);
    chk("s3_dones", d, 1);
    seq_compare("s3_seq_same");

    // Scenario 4: reset at j=30 aborts without done
    @(posedge clk); #1;
    start_block(abc);
    ready = 1'b1;
    k = 0;
    while (j != 6'd30 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("s4_reach_j30", j, 30);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("s4_valid", valid, 0);
    chk("s4_busy", busy, 0);
    chk("s4_j", j, 0);
    chk("s4_done", done, 0);
    @(posedge clk); #1;
    chk("s4_no_done_later", done, 0);
    start_block(abc);
    chk("s4_restart_W", w, 32'h61626380);
    run_stream(0, -1, '0, d);

    // Scenario 5: start in the done cycle is accepted
    start_block(abc);
    run_stream(0, -1, '0, d);
    chk("s5_dones", d, 1);
    seq_compare("s5_seq_same");

    // Random blocks against the recurrence model
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      start_block(rand_block());
      run_stream(30, -1, '0, d);
      chk("rand_dones", d, 1);
    end

    // Scenario 6: start held across three blocks
    @(posedge clk); #1;
    build_model(abc);
    blk = abc; start = 1'b1; ready = 1'b1;
    hs6 = 0; dn6 = 0; k = 0;
    while (dn6 < 3 && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (done) dn6++;
      if (valid) begin
        chk("s6_j", j, hs6 % 64);
        chk("s6_W", w, mw[j]);
        hs6++;
      end
    end
    start = 1'b0;
    chk("s6_dones", dn6, 3);
    chk("s6_handshakes", hs6, 192);
    @(posedge clk); #1;
    chk("s6_idle_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
